// File: rtl/spi_pkg.sv
// Shared types for the multi-mode SPI master: FSM states, SPI mode encoding and the
// four standard mode constants.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD
   } spi_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
   localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
   localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
   localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period tick generator: counts HALF clk cycles per tick and tags each tick
// during the data phase as a leading or trailing sclk edge.
module spi_sclk_gen #(
   parameter int unsigned HALF = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   input  logic xfer,
   output logic tick_c,
   output logic lead_c,
   output logic trail_c
);

   localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CNT_W-1:0] cnt;
   logic             phase;

   assign tick_c  = en && (cnt == CNT_W'(HALF - 1));
   assign lead_c  = tick_c && xfer && !phase;
   assign trail_c = tick_c && xfer && phase;

   // phase flips on every data-phase tick, so even toggles are leading edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (clr) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (en) begin
         cnt <= tick_c ? '0 : cnt + 1'b1;
         if (tick_c && xfer) phase <= ~phase;
      end
   end

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with runtime CPOL/CPHA, bit order selection, parametric word width
// and one-hot chip selects.
module spi_master_mc
   import spi_pkg::*;
#(
   parameter  int unsigned DATA_W  = 8,
   parameter  int unsigned NUM_CS  = 1,
   parameter  int unsigned CLK_DIV = 4,
   localparam int unsigned CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic [1:0]        mode,
   input  logic              lsb_first,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int unsigned H     = CLK_DIV / 2;
   localparam int unsigned TOG_W = $clog2(2 * DATA_W);
   localparam int unsigned IDX_W = TOG_W - 1;
   localparam int unsigned LAST  = 2 * DATA_W - 1;

   spi_state_e        state;
   spi_mode_t         cfg;
   logic              lsb_q;
   logic [DATA_W-1:0] tx_q;
   logic [DATA_W-1:0] rx_sr;
   logic [TOG_W-1:0]  tog;

   logic              tick_c, lead_c, trail_c;
   logic              sample_c, shift_c, last_c, mosi_nxt_c;
   logic [IDX_W-1:0]  idx_c;
   logic [NUM_CS-1:0] cs_dec_c;

   spi_sclk_gen #(.HALF(H)) u_sclk_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (state != IDLE),
      .clr     (state == IDLE),
      .xfer    (state == XFER),
      .tick_c  (tick_c),
      .lead_c  (lead_c),
      .trail_c (trail_c)
   );

   // idx_c is the position (in shift order) of the bit mosi moves to on this toggle
   always_comb begin
      last_c     = (tog == TOG_W'(LAST));
      sample_c   = cfg.cpha ? trail_c : lead_c;
      shift_c    = cfg.cpha ? lead_c : (trail_c && !last_c);
      idx_c      = cfg.cpha ? tog[TOG_W-1:1] : tog[TOG_W-1:1] + 1'b1;
      mosi_nxt_c = lsb_q ? tx_q[idx_c] : tx_q[IDX_W'(DATA_W - 1) - idx_c];
   end

   // out-of-range cs_sel matches no slave and leaves every select high
   always_comb begin
      cs_dec_c = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cs_sel == CS_W'(i)) cs_dec_c[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cfg     <= SPI_MODE0;
         lsb_q   <= 1'b0;
         tx_q    <= '0;
         rx_sr   <= '0;
         tog     <= '0;
         rx_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         cs_n    <= '1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               sclk <= mode[1];
               if (start) begin
                  state <= SETUP;
                  cfg   <= spi_mode_t'(mode);
                  lsb_q <= lsb_first;
                  tx_q  <= tx_data;
                  tog   <= '0;
                  busy  <= 1'b1;
                  cs_n  <= cs_dec_c;
                  mosi  <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
               end
            end
            SETUP: begin
               if (tick_c) state <= XFER;
            end
            XFER: begin
               if (tick_c) begin
                  sclk <= ~sclk;
                  if (sample_c) begin
                     rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
                  end
                  if (shift_c) mosi <= mosi_nxt_c;
                  if (last_c) state <= HOLD;
                  else        tog   <= tog + 1'b1;
               end
            end
            HOLD: begin
               if (tick_c) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  cs_n    <= '1;
                  sclk    <= cfg.cpol;
                  rx_data <= rx_sr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_mc.sv
// Randomised bench for spi_master_mc: a behavioural SPI slave counts sclk edges,
// feeds miso, captures mosi and predicts rx, cs_n and completion timing.
module tb_spi_master_mc;
   import spi_pkg::*;

   localparam int unsigned DW       = 8;
   localparam int unsigned CLK_DIV  = 4;
   localparam int unsigned H        = CLK_DIV / 2;
   localparam int unsigned XFER_CYC = (2 * DW + 2) * H;
   localparam spi_mode_t   MODES [3] = '{SPI_MODE1, SPI_MODE2, SPI_MODE3};

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          lsb_first = 1'b0;
   logic          miso = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic [1:0]    mode = '0;
   logic [2:0]    sel = '0;

   logic [DW-1:0] rx_a, rx_b;
   logic          busy_a, done_a, sclk_a, mosi_a;
   logic          busy_b, done_b, sclk_b, mosi_b;
   logic [3:0]    cs_a;
   logic [5:0]    cs_b;

   int checks = 0;
   int failures = 0;

   spi_master_mc #(.DATA_W(DW), .NUM_CS(4), .CLK_DIV(CLK_DIV)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .cs_sel(sel[1:0]),
      .mode(mode), .lsb_first(lsb_first), .rx_data(rx_a), .busy(busy_a), .done(done_a),
      .sclk(sclk_a), .mosi(mosi_a), .miso(miso), .cs_n(cs_a)
   );

   spi_master_mc #(.DATA_W(DW), .NUM_CS(6), .CLK_DIV(CLK_DIV)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .cs_sel(sel),
      .mode(mode), .lsb_first(lsb_first), .rx_data(rx_b), .busy(busy_b), .done(done_b),
      .sclk(sclk_b), .mosi(mosi_b), .miso(miso), .cs_n(cs_b)
   );

   always #5 clk = ~clk;

   a_cs_a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~cs_a));
   a_cs_b_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~cs_b));
   a_done_pulse:  assert property (@(posedge clk) disable iff (!rst_n) done_a |=> !done_a);
   a_sclk_idle:   assert property (@(posedge clk) disable iff (!rst_n)
                     (&cs_a && !busy_a && $past(!busy_a) && $stable(mode[1])) |=> $stable(sclk_a));
   a_pins_match:  assert property (@(posedge clk) disable iff (!rst_n)
                     (sclk_b == sclk_a) && (mosi_b == mosi_a) && (busy_b == busy_a));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic sent_bit(input logic [DW-1:0] w, input int k, input bit lsb);
      return lsb ? w[k] : w[DW-1-k];
   endfunction

   function automatic logic [5:0] cs_mask(input int s, input int n);
      logic [5:0] m = '1;
      if (s < n) m[s] = 1'b0;
      return m;
   endfunction

   // One transfer against the slave model; b2b_in: starts in the previous done cycle,
   // b2b_out: return in the done cycle; poke_at: cycle to pulse start (or reset if abort)
   task automatic xfer(input logic [DW-1:0] tx, input logic [DW-1:0] slv, input logic [1:0] md,
                       input bit lsb, input logic [2:0] s, input bit loop, input bit b2b_in,
                       input bit b2b_out, input int poke_at, input bit abort);
      int            e = 0, rises = 0, c = 0, k;
      bit            fin = 0, rx_moved = 0;
      logic          prev_sclk;
      logic [DW-1:0] got = '0;
      logic [DW-1:0] rx_prev;
      logic [5:0]    ma, mb;
      ma = cs_mask(int'(s[1:0]), 4);
      mb = cs_mask(int'(s), 6);
      if (!b2b_in) begin
         mode = md;
         @(negedge clk);
         check("idle_sclk", sclk_a, md[1]);
      end
      rx_prev   = rx_a;
      tx_data   = tx;
      mode      = md;
      lsb_first = lsb;
      sel       = s;
      start     = 1'b1;
      prev_sclk = md[1];
      @(negedge clk);
      start = 1'b0;
      check("busy_on", busy_a, 1'b1);
      check("cs_a_sel", cs_a, ma[3:0]);
      check("cs_b_sel", cs_b, mb);
      check("first_mosi", mosi_a, sent_bit(tx, 0, lsb));
      while (!fin && c <= 4 * XFER_CYC) begin
         if (sclk_a !== prev_sclk) begin
            e++;
            prev_sclk = sclk_a;
            if (sclk_a) rises++;
            if ((e % 2) == (md[0] ? 0 : 1)) begin
               k = (e - 1) / 2;
               if (k < DW) begin
                  if (lsb) got[k] = mosi_a;
                  else     got[DW-1-k] = mosi_a;
               end
            end
         end
         k = md[0] ? ((e > 0) ? (e - 1) / 2 : 0) : e / 2;
         if (k >= DW) k = DW - 1;
         miso = loop ? mosi_a : sent_bit(slv, k, lsb);
         if (done_a) begin
            fin = 1;
            check("latency", c, XFER_CYC);
            check("rx_a", rx_a, loop ? tx : slv);
            check("rx_b", rx_b, loop ? tx : slv);
            check("done_b", done_b, 1'b1);
            check("mosi_word", got, tx);
            check("sclk_rises", rises, DW);
            check("sclk_end", sclk_a, md[1]);
            check("busy_off", busy_a, 1'b0);
            check("cs_a_idle", cs_a, 4'hF);
            check("cs_b_idle", cs_b, 6'h3F);
            check("rx_stable", rx_moved, 1'b0);
         end else begin
            if (rx_a !== rx_prev) rx_moved = 1;
            if (c == poke_at && abort) begin
               rst_n = 1'b0;
               mode  = '0;
               #1;
               check("rst_sclk", sclk_a, 1'b0);
               check("rst_mosi", mosi_a, 1'b0);
               check("rst_cs", {cs_b, cs_a}, 10'h3FF);
               check("rst_busy", busy_a, 1'b0);
               check("rst_rx", rx_a, '0);
               fin = 0;
               repeat (3) begin
                  @(negedge clk);
                  if (done_a) fin = 1;
               end
               check("rst_no_done", fin, 1'b0);
               rst_n = 1'b1;
               repeat (2) @(negedge clk);
               return;
            end
            if (c == poke_at) begin
               start     = 1'b1;
               tx_data   = ~tx;
               mode      = ~md;
               lsb_first = ~lsb;
               sel       = s ^ 3'h1;
            end
            if (c == poke_at + 1) start = 1'b0;
            @(negedge clk);
            c++;
         end
      end
      if (!fin) check("done_timeout", 1'b0, 1'b1);
      if (!b2b_out) begin
         mode  = md;
         start = 1'b0;
         @(negedge clk);
         check("done_1cyc", done_a, 1'b0);
         repeat (2) @(negedge clk);
         check("no_requeue", busy_a, 1'b0);
      end
   endtask

   initial begin
      bit         prev_b2b, nxt;
      logic [1:0] md_r;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outs", {rx_a, busy_a, done_a, sclk_a, mosi_a, cs_a}, {8'h00, 4'b0000, 4'hF});
      check("reset_cs_b", cs_b, 6'h3F);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      xfer(8'hA5, 8'h00, SPI_MODE0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      for (int i = 0; i < 3; i++)
         xfer(8'h3C, 8'hC3, MODES[i], 1'b0, 3'(i + 1), 1'b0, 1'b0, 1'b0, -1, 1'b0);
      xfer(8'h01, 8'h80, SPI_MODE0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      xfer(8'h5A, 8'h96, SPI_MODE1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      xfer(8'hF0, 8'h0F, SPI_MODE2, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      xfer(8'h33, 8'hE7, SPI_MODE3, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      xfer(8'h6B, 8'h2D, SPI_MODE0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 10, 1'b0);
      xfer(8'h9E, 8'hB1, SPI_MODE0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
      xfer(8'hC4, 8'h71, SPI_MODE0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 10, 1'b1);
      xfer(8'h4D, 8'hA8, SPI_MODE0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, -1, 1'b0);

      prev_b2b = 1'b0;
      md_r     = '0;
      for (int n = 0; n < 24; n++) begin
         nxt = (n < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (!prev_b2b) md_r = 2'($urandom_range(0, 3));
         xfer(DW'($urandom), DW'($urandom), md_r, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), prev_b2b, nxt, -1, 1'b0);
         prev_b2b = nxt;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
